miniosii_nios2_gen2_0_cpu_div_cell: RTL and testbench
=====================================================

# miniosII_nios2_gen2_0_cpu_div_cell

Iterative 32-bit integer divider for the Nios II gen2 execute/memory datapath; it is the inverse-direction companion of the CPU multiply cell. The block accepts dividend and divisor from E-stage, runs a radix-2 restoring division over 32 iterations, and returns the quotient to M-stage with a done pulse. Both `div` (signed) and `divu` (unsigned) are supported. The pipeline stalls on `M_div_busy`.

## Interface
- `DATA_W`, default 32: operand, quotient and remainder width. Only 32 is supported.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `E_src1`  in  32: dividend, sampled on the start cycle.
- `E_src2`  in  32: divisor, sampled on the start cycle.
- `E_div_start`  in  1: start request; accepted only in IDLE.
- `E_div_signed`  in  1: 1 selects `div` (two's complement), 0 selects `divu`; sampled with start.
- `E_div_kill`  in  1: pipeline flush; abandons an operation in progress.
- `M_div_busy`  out  1: high from the cycle after start acceptance until done.
- `M_div_done`  out  1: single-cycle pulse; result valid.
- `M_div_result`  out  32: quotient; held until the next accepted start.
- `M_div_remainder`  out  32: present only with `MINIOS_DIV_REMAINDER_EN`.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE:** on `E_div_start`, latch the following, load a 6-bit count with 31, then go to RUN:
  - |src1| into the quotient/shift register and |src2| into the divisor register;
  - the sign flags: quotient sign = sign1 XOR sign2, remainder sign = sign1 (signed mode only; unsigned uses raw values).
- **RUN:** each cycle performs one restoring step:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor, computed 33 bits wide;
  - if trial is non-negative, rem = trial and the quotient LSB = 1; otherwise the quotient LSB = 0;
  - at count 0 go to FIX, else decrement the count.
- **FIX:** negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. Register the results, pulse done, go to IDLE.
- **Start while busy:** ignored and not queued.
- **Kill:** `E_div_kill` in RUN or FIX returns the block to IDLE next cycle. There is no done pulse, and the result registers keep their previous value. Kill in IDLE has no effect. Kill and start in the same IDLE cycle: kill wins, and the start is dropped.
- **Divide by zero:** no trap. The natural algorithm outcome is the defined result:
  - unsigned: quotient 0xFFFFFFFF, remainder = dividend;
  - signed: quotient = 0xFFFFFFFF when the dividend is ≥ 0, 0x00000001 when it is < 0; remainder = dividend.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
- **Magnitude of 0x80000000:** represented correctly as unsigned 32-bit.
- **Reset:** returns the block to IDLE from any state (including mid-RUN), with:
  - `M_div_busy` = 0, `M_div_done` = 0;
  - `M_div_result` = 0, `M_div_remainder` = 0;
  - all internal registers = 0.

## Timing
- Start high in cycle 0 → busy high in cycles 1–33 → done high in cycle 34 with result valid → busy low in cycle 34.
- Fixed latency of 34 cycles; there is no early termination.
- A new start is accepted in cycle 34 (done cycle, state IDLE) at the earliest. Back-to-back throughput is one divide per 34 cycles.
- Kill in cycle n (1 ≤ n ≤ 33) → busy low in cycle n+1.
- Inputs are sampled only at start acceptance. E_src values may change freely afterwards.

## Configuration
- `MINIOS_DIV_REMAINDER_EN`
  - Defined: the `M_div_remainder` port exists, and the sign-corrected remainder is registered in FIX.
  - Undefined: the port and its output register are omitted. Internal rem datapath is unchanged (needed by the algorithm); the quotient is bit-identical in both builds.

## Structure
- Package `miniosII_div_pkg` holds:
  - the state enum (IDLE/RUN/FIX);
  - `DIV_W` = 32;
  - `DIV_CNT_W` = 6;
  - `DIV_ITER` = 32;
  - a function for conditional two's-complement negation.
- One sub-module, `miniosII_div_step`: a purely combinational single restoring step. It takes {rem, quo, divisor} and returns {rem_next, quo_next}. It is instantiated once inside the RUN datapath.

## Test plan
- Unsigned 100 / 7, start in cycle 0 → done in cycle 34 only; quotient 14, remainder 2; busy high in cycles 1–33.
- Signed with remainder, all with start in cycle 0:
  - −7 / 2 (0xFFFFFFF9 / 2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF;
  - 7 / −2 → quotient 0xFFFFFFFD, remainder 1.
- Corner cases:
  - signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0;
  - unsigned 0xFFFFFFFF / 1 → quotient 0xFFFFFFFF.
- Divide by zero:
  - unsigned 5 / 0 → quotient 0xFFFFFFFF, remainder 5;
  - signed −5 / 0 → quotient 1, remainder 0xFFFFFFFB.
- Control:
  - kill in cycle 10 → busy low in cycle 11, no done, previous result unchanged;
  - start pulsed in cycle 5 while busy → ignored, only one done, in cycle 34.
- Reset asserted in cycle 20 of a divide → next cycle busy = 0, done = 0, result = 0. A fresh 9 / 3 started afterwards gives quotient 3 with done 34 cycles after its start.

Source files
------------

// File: rtl/miniosII_div_pkg.sv
// Shared types and constants for the Nios II gen2 iterative divider.
package miniosII_div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 6;
  localparam int DIV_ITER  = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

  // Two's-complement negate v when en is set, pass it through otherwise.
  function automatic logic [DIV_W-1:0] neg_if(input logic [DIV_W-1:0] v, input logic en);
    return en ? (DIV_W'(0) - v) : v;
  endfunction

endpackage

// File: rtl/miniosII_div_step.sv
// One combinational restoring-division step on {rem, quo}.
module miniosII_div_step
  import miniosII_div_pkg::*;
(
  input  logic [DIV_W-1:0] rem,
  input  logic [DIV_W-1:0] quo,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_next,
  output logic [DIV_W-1:0] quo_next
);

  logic [DIV_W:0] rem_sh;
  logic [DIV_W:0] trial;

  // Shift {rem, quo} left one bit, try the subtraction, keep it only if it did not go negative.
  // rem < divisor on entry, so a successful trial always fits in DIV_W bits and a failed one
  // always sets the top bit of the 33-bit difference.
  always_comb begin
    rem_sh   = {rem, quo[DIV_W-1]};
    trial    = rem_sh - {1'b0, divisor};
    rem_next = trial[DIV_W] ? rem_sh[DIV_W-1:0] : trial[DIV_W-1:0];
    quo_next = {quo[DIV_W-2:0], ~trial[DIV_W]};
  end

endmodule

// File: rtl/miniosii_nios2_gen2_0_cpu_div_cell.sv
// Iterative 32-bit restoring divider (div / divu) for the Nios II gen2 E/M datapath.
// Optional remainder output: define MINIOS_DIV_REMAINDER_EN.
//
// Handshake: E_div_start is a request that is taken only when the cell is idle and no kill is
// present in the same cycle; there is no back-pressure and no queuing, a start seen while busy is
// dropped. M_div_busy is high from the cycle after acceptance until the done cycle, and
// M_div_done is a one-cycle pulse in which M_div_result (and the remainder) are valid; the
// result registers then hold until the next completed divide.
module miniosii_nios2_gen2_0_cpu_div_cell
  import miniosII_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  input  logic              E_div_kill,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_result,
`ifdef MINIOS_DIV_REMAINDER_EN
  output logic [DATA_W-1:0] M_div_remainder,
`endif
  output logic [1:0]        div_state_dbg
);

  div_state_e           state_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [DIV_W-1:0]     rem_q;
  logic [DIV_W-1:0]     quo_q;
  logic [DIV_W-1:0]     dvs_q;
  logic                 q_sign_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DIV_W-1:0]     result_q;
`ifdef MINIOS_DIV_REMAINDER_EN
  logic                 r_sign_q;
  logic [DIV_W-1:0]     remainder_q;
`endif

  logic [DIV_W-1:0] rem_next;
  logic [DIV_W-1:0] quo_next;
  logic             neg1;
  logic             neg2;

  miniosII_div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Operand sign flags; only meaningful for signed div.
  always_comb begin
    neg1 = E_div_signed & E_src1[DIV_W-1];
    neg2 = E_div_signed & E_src2[DIV_W-1];
  end

  // Control FSM plus datapath registers: IDLE latches magnitudes, RUN iterates, FIX sign-corrects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_sign_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
`ifdef MINIOS_DIV_REMAINDER_EN
      r_sign_q    <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        DIV_IDLE: begin
          if (E_div_start && !E_div_kill) begin
            rem_q    <= '0;
            quo_q    <= neg_if(E_src1, neg1);
            dvs_q    <= neg_if(E_src2, neg2);
            q_sign_q <= neg1 ^ neg2;
`ifdef MINIOS_DIV_REMAINDER_EN
            r_sign_q <= neg1;
`endif
            cnt_q    <= DIV_CNT_W'(DIV_ITER - 1);
            busy_q   <= 1'b1;
            state_q  <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (E_div_kill) begin
            busy_q  <= 1'b0;
            state_q <= DIV_IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (cnt_q == '0) begin
              state_q <= DIV_FIX;
            end else begin
              cnt_q <= cnt_q - DIV_CNT_W'(1);
            end
          end
        end
        DIV_FIX: begin
          busy_q  <= 1'b0;
          state_q <= DIV_IDLE;
          if (!E_div_kill) begin
            result_q    <= neg_if(quo_q, q_sign_q);
`ifdef MINIOS_DIV_REMAINDER_EN
            remainder_q <= neg_if(rem_q, r_sign_q);
`endif
            done_q      <= 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign M_div_busy      = busy_q;
  assign M_div_done      = done_q;
  assign M_div_result    = result_q;
`ifdef MINIOS_DIV_REMAINDER_EN
  assign M_div_remainder = remainder_q;
`endif
  assign div_state_dbg   = state_q;

endmodule

// File: tb/tb_miniosii_nios2_gen2_0_cpu_div_cell.sv
// Directed bench for the iterative divider. Cycle 0 is the cycle in which start is driven;
// outputs are sampled on the falling edge after each rising edge.
module tb_miniosii_nios2_gen2_0_cpu_div_cell;

  logic        clk;
  logic        reset;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        start;
  logic        sgn;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  state_dbg;
`ifdef MINIOS_DIV_REMAINDER_EN
  logic [31:0] remainder;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  miniosii_nios2_gen2_0_cpu_div_cell #(.DATA_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .E_src1          (src1),
    .E_src2          (src2),
    .E_div_start     (start),
    .E_div_signed    (sgn),
    .E_div_kill      (kill),
    .M_div_busy      (busy),
    .M_div_done      (done),
    .M_div_result    (result),
`ifdef MINIOS_DIV_REMAINDER_EN
    .M_div_remainder (remainder),
`endif
    .div_state_dbg   (state_dbg)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one start in cycle 0, then watch cycles 1..45. Optional kill / extra start cycles
  // (0 = none). Operands are scrambled after the start cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int kill_cyc, input int poke_cyc,
                        output int done_cnt, output int first_done,
                        output int busy_cnt, output int last_busy);
    @(negedge clk);
    src1 = a; src2 = b; sgn = s; start = 1'b1; kill = 1'b0;
    done_cnt = 0; first_done = -1; busy_cnt = 0; last_busy = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = 1'b0;
      kill  = 1'b0;
      src1  = $urandom;
      src2  = $urandom_range(0, 255);
      sgn   = 1'($urandom_range(0, 1));
      if (busy) begin busy_cnt++; last_busy = k; end
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = k;
      end
      if (k == kill_cyc) kill = 1'b1;
      if (k == poke_cyc) begin
        start = 1'b1;
        src1  = 32'd77;
        src2  = 32'd11;
      end
    end
  endtask

  task automatic div_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_q, input logic [31:0] exp_r);
    int dc, fd, bc, lb;
    run_op(a, b, s, 0, 0, dc, fd, bc, lb);
    check({tag, "_done_cnt"}, 32'(dc), 32'd1);
    check({tag, "_done_cyc"}, 32'(fd), 32'd34);
    check({tag, "_busy_cnt"}, 32'(bc), 32'd33);
    check({tag, "_busy_last"}, 32'(lb), 32'd33);
    check({tag, "_quo"}, result, exp_q);
`ifdef MINIOS_DIV_REMAINDER_EN
    check({tag, "_rem"}, remainder, exp_r);
`else
    if (exp_r !== exp_r) $display("unreachable");
`endif
  endtask

  initial begin
    int dc, fd, bc, lb;
    reset = 1'b1; src1 = '0; src2 = '0; start = 1'b0; sgn = 1'b0; kill = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
`ifdef MINIOS_DIV_REMAINDER_EN
    check("rst_rem", remainder, 32'd0);
`endif
    reset = 1'b0;

    div_case("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
    div_case("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
    div_case("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1);
    div_case("s_ovf",    32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0);
    div_case("u_max_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0);
    div_case("u_dz",     32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5);
    div_case("s_m5_dz",  32'hFFFF_FFFB,  32'd0,          1'b1, 32'd1,          32'hFFFF_FFFB);
    div_case("s_5_dz",   32'd5,          32'd0,          1'b1, 32'hFFFF_FFFF,  32'd5);
    div_case("u100_7b",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2);

    // Kill in cycle 10: busy drops in cycle 11, no done, previous quotient 14 held.
    run_op(32'd50, 32'd5, 1'b0, 10, 0, dc, fd, bc, lb);
    check("kill_done_cnt", 32'(dc), 32'd0);
    check("kill_busy_cnt", 32'(bc), 32'd10);
    check("kill_busy_last", 32'(lb), 32'd10);
    check("kill_result", result, 32'd14);
    check("kill_state", 32'(state_dbg), 32'd0);

    // Start pulsed in cycle 5 while busy is ignored.
    run_op(32'd1000, 32'd10, 1'b0, 0, 5, dc, fd, bc, lb);
    check("poke_done_cnt", 32'(dc), 32'd1);
    check("poke_done_cyc", 32'(fd), 32'd34);
    check("poke_busy_last", 32'(lb), 32'd33);
    check("poke_result", result, 32'd100);

    // Reset in cycle 20 of a divide.
    @(negedge clk);
    src1 = 32'd123; src2 = 32'd4; sgn = 1'b0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
`ifdef MINIOS_DIV_REMAINDER_EN
    check("mid_rst_rem", remainder, 32'd0);
`endif
    div_case("u9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
